// File: rtl/breakout_sequencer.sv
// Game-phase sequencer for a breakout datapath: button conditioning, ball-step timing,
// score/lives bookkeeping. All outputs come from registers or decoded registered state.
module breakout_sequencer #(
  parameter int TICK_DIV    = 50000,
  parameter int PAUSE_TICKS = 120,
  parameter int START_LIVES = 3,
  parameter int WIN_SCORE   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_serve,
  input  logic       btn_pause,
  input  logic       ball_out,
  input  logic       brick_hit,
  input  logic [7:0] bricks_left,
  output logic [2:0] phase,
  output logic       ball_tick,
  output logic       serve,
  output logic       hold_ball,
  output logic       new_game,
  output logic [1:0] lives,
  output logic [7:0] score
);

  typedef enum logic [2:0] {
    READY  = 3'd0,
    PLAY   = 3'd1,
    PAUSED = 3'd2,
    LOST   = 3'd3,
    OVER   = 3'd4,
    WON    = 3'd5
  } phase_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_TICKS - 1);
  localparam logic [8:0]    WIN_LIM    = 9'(WIN_SCORE);
  localparam logic [1:0]    LIVES_INIT = 2'(START_LIVES);

  phase_t        state;
  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] pause_cnt;

  // [0],[1] synchronize; [2] is the previous synchronized level for edge detection
  logic [2:0] srv_sync, pau_sync;
  logic       srv_armed, pau_armed;
  logic [1:0] warm;

  logic          serve_edge, pause_edge;
  logic          tick_wrap, win;
  logic [TW-1:0] tick_nxt;
  logic [8:0]    score_sum;
  logic [7:0]    score_sat;

  // A button only arms once its synchronized level is seen low after reset,
  // so a button held through reset release never produces an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      srv_sync  <= '0;
      pau_sync  <= '0;
      srv_armed <= 1'b0;
      pau_armed <= 1'b0;
      warm      <= '0;
    end else begin
      srv_sync <= {srv_sync[1:0], btn_serve};
      pau_sync <= {pau_sync[1:0], btn_pause};
      if (warm != 2'd2) warm <= warm + 2'd1;
      if (warm == 2'd2 && !srv_sync[1]) srv_armed <= 1'b1;
      if (warm == 2'd2 && !pau_sync[1]) pau_armed <= 1'b1;
    end
  end

  assign serve_edge = srv_armed & srv_sync[1] & ~srv_sync[2];
  assign pause_edge = pau_armed & pau_sync[1] & ~pau_sync[2];

  assign tick_wrap = (tick_cnt == TICK_LAST);
  assign tick_nxt  = tick_wrap ? '0 : tick_cnt + TW'(1);
  assign score_sum = {1'b0, score} + {8'd0, brick_hit};
  assign score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];
  assign win       = (bricks_left == 8'd0) || (score_sum >= WIN_LIM);

  assign phase     = state;
  assign hold_ball = (state == READY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= READY;
      lives     <= LIVES_INIT;
      score     <= '0;
      tick_cnt  <= '0;
      pause_cnt <= '0;
      ball_tick <= 1'b0;
      serve     <= 1'b0;
      new_game  <= 1'b0;
    end else begin
      ball_tick <= 1'b0;
      serve     <= 1'b0;
      new_game  <= 1'b0;
      case (state)
        READY: begin
          if (serve_edge) begin
            state     <= PLAY;
            serve     <= 1'b1;
            tick_cnt  <= '0;
            ball_tick <= (TICK_LAST == '0);
          end
        end
        PLAY: begin
          score <= score_sat;
          if (win) begin
            state <= WON;
          end else if (ball_out) begin
            state     <= (lives > 2'd1) ? LOST : OVER;
            lives     <= (lives > 2'd1) ? lives - 2'd1 : 2'd0;
            tick_cnt  <= '0;
            pause_cnt <= '0;
          end else if (pause_edge) begin
            state <= PAUSED;
          end else begin
            tick_cnt  <= tick_nxt;
            ball_tick <= (tick_nxt == TICK_LAST);
          end
        end
        PAUSED: begin
          // Count stays frozen; resuming re-emits a tick if it froze on the last step
          if (pause_edge) begin
            state     <= PLAY;
            ball_tick <= tick_wrap;
          end
        end
        LOST: begin
          tick_cnt <= tick_nxt;
          if (tick_wrap) begin
            if (pause_cnt == PAUSE_LAST) begin
              state     <= READY;
              pause_cnt <= '0;
            end else begin
              pause_cnt <= pause_cnt + PW'(1);
            end
          end
        end
        OVER, WON: begin
          if (serve_edge) begin
            state    <= READY;
            lives    <= LIVES_INIT;
            score    <= '0;
            new_game <= 1'b1;
          end
        end
        default: state <= READY;
      endcase
    end
  end

endmodule

// File: tb/tb_breakout_sequencer.sv
// Scoreboard bench for breakout_sequencer: expected state changes and pulse cycles are
// queued as stimulus is driven and popped by a negedge monitor as the DUT produces them.
module tb_breakout_sequencer;

  localparam logic [2:0] READY = 3'd0, PLAY = 3'd1, PAUSED = 3'd2,
                         LOST = 3'd3, OVER = 3'd4, WON = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_serve = 1'b0, btn_pause = 1'b0, ball_out = 1'b0, brick_hit = 1'b0;
  logic [7:0] bricks_left = 8'd50;
  logic [2:0] phase;
  logic       ball_tick, serve, hold_ball, new_game;
  logic [1:0] lives;
  logic [7:0] score;

  breakout_sequencer #(
    .TICK_DIV(4), .PAUSE_TICKS(2), .START_LIVES(3), .WIN_SCORE(3)
  ) dut (
    .clk(clk), .reset(reset), .btn_serve(btn_serve), .btn_pause(btn_pause),
    .ball_out(ball_out), .brick_hit(brick_hit), .bricks_left(bricks_left),
    .phase(phase), .ball_tick(ball_tick), .serve(serve), .hold_ball(hold_ball),
    .new_game(new_game), .lives(lives), .score(score)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [2:0] ph;
    logic [1:0] lv;
    logic [7:0] sc;
  } ev_t;

  ev_t ev_q[$];
  int  tick_q[$];
  int  serve_q[$];
  int  ng_q[$];
  logic [2:0] last_ph = READY;
  logic [1:0] last_lv = 2'd3;
  logic [7:0] last_sc = 8'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if ({phase, lives, score} !== {last_ph, last_lv, last_sc}) begin
      if (ev_q.size() == 0) begin
        check_val("unexpected_state", 32'({phase, lives, score}), 32'({last_ph, last_lv, last_sc}));
      end else begin
        e = ev_q.pop_front();
        check_val("ev_cycle", cyc, e.c);
        check_val("phase", 32'(phase), 32'(e.ph));
        check_val("lives", 32'(lives), 32'(e.lv));
        check_val("score", 32'(score), 32'(e.sc));
        check_val("hold_ball", 32'(hold_ball), 32'(e.ph == READY));
      end
      last_ph = phase;
      last_lv = lives;
      last_sc = score;
    end
    if (ball_tick) begin
      if (tick_q.size() == 0) check_val("tick_extra", cyc, 32'hFFFF_FFFF);
      else check_val("tick_cycle", cyc, tick_q.pop_front());
    end
    if (serve) begin
      if (serve_q.size() == 0) check_val("serve_extra", cyc, 32'hFFFF_FFFF);
      else check_val("serve_cycle", cyc, serve_q.pop_front());
    end
    if (new_game) begin
      if (ng_q.size() == 0) check_val("new_game_extra", cyc, 32'hFFFF_FFFF);
      else check_val("new_game_cycle", cyc, ng_q.pop_front());
    end
  end

  task automatic waitc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_ev(input int c, input logic [2:0] ph, input logic [1:0] lv, input logic [7:0] sc);
    ev_t e;
    e.c = c; e.ph = ph; e.lv = lv; e.sc = sc;
    ev_q.push_back(e);
  endtask

  // A press first sampled at edge N acts at edge N+2, visible at the following negedge.
  task automatic do_serve(input logic [2:0] ph, input logic [1:0] lv, input logic [7:0] sc, output int t);
    int k;
    k = cyc;
    btn_serve = 1'b1;
    push_ev(k + 3, ph, lv, sc);
    if (ph == PLAY) serve_q.push_back(k + 3);
    else ng_q.push_back(k + 3);
    waitc(3);
    btn_serve = 1'b0;
    t = k + 3;
  endtask

  task automatic do_pause(input logic [2:0] ph, input logic [1:0] lv, input logic [7:0] sc, output int t);
    int k;
    k = cyc;
    btn_pause = 1'b1;
    push_ev(k + 3, ph, lv, sc);
    waitc(3);
    btn_pause = 1'b0;
    t = k + 3;
  endtask

  task automatic pulse(input logic bo, input logic bh, input bit expect_ev,
                       input logic [2:0] ph, input logic [1:0] lv, input logic [7:0] sc);
    if (expect_ev) push_ev(cyc + 1, ph, lv, sc);
    ball_out  = bo;
    brick_hit = bh;
    @(negedge clk);
    ball_out  = 1'b0;
    brick_hit = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t, l, c;
    #1 reset = 1'b0;
    #2;
    check_val("rst_phase", 32'(phase), 32'(READY));
    check_val("rst_lives", 32'(lives), 32'd3);
    check_val("rst_score", 32'(score), 32'd0);
    check_val("rst_ball_tick", 32'(ball_tick), 32'd0);
    check_val("rst_serve", 32'(serve), 32'd0);
    check_val("rst_new_game", 32'(new_game), 32'd0);
    check_val("rst_hold_ball", 32'(hold_ball), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    waitc(5);

    // Serve, ticks every 4th cycle, three bricks win the game, re-serve for a new game
    pulse(1'b1, 1'b1, 1'b0, READY, 2'd3, 8'd0);
    waitc(2);
    do_serve(PLAY, 2'd3, 8'd0, t);
    tick_q.push_back(t + 3);
    tick_q.push_back(t + 7);
    wait_until(t + 8);
    pulse(1'b0, 1'b1, 1'b1, PLAY, 2'd3, 8'd1);
    pulse(1'b0, 1'b1, 1'b1, PLAY, 2'd3, 8'd2);
    pulse(1'b0, 1'b1, 1'b1, WON, 2'd3, 8'd3);
    pulse(1'b1, 1'b1, 1'b0, WON, 2'd3, 8'd3);
    waitc(6);
    do_serve(READY, 2'd3, 8'd0, t);
    waitc(4);

    // Lose all three lives; serve pressed during LOST must be ignored
    do_serve(PLAY, 2'd3, 8'd0, t);
    waitc(2);
    pulse(1'b1, 1'b0, 1'b1, LOST, 2'd2, 8'd0);
    l = cyc;
    push_ev(l + 8, READY, 2'd2, 8'd0);
    btn_serve = 1'b1;
    waitc(3);
    btn_serve = 1'b0;
    wait_until(l + 10);
    do_serve(PLAY, 2'd2, 8'd0, t);
    waitc(2);
    pulse(1'b1, 1'b0, 1'b1, LOST, 2'd1, 8'd0);
    push_ev(cyc + 8, READY, 2'd1, 8'd0);
    waitc(10);
    do_serve(PLAY, 2'd1, 8'd0, t);
    waitc(2);
    pulse(1'b1, 1'b0, 1'b1, OVER, 2'd0, 8'd0);
    waitc(2);
    pulse(1'b1, 1'b1, 1'b0, OVER, 2'd0, 8'd0);
    waitc(2);
    do_serve(READY, 2'd3, 8'd0, t);
    waitc(4);

    // Winning brick and ball_out in the same cycle: win takes priority
    do_serve(PLAY, 2'd3, 8'd0, t);
    pulse(1'b0, 1'b1, 1'b1, PLAY, 2'd3, 8'd1);
    pulse(1'b0, 1'b1, 1'b1, PLAY, 2'd3, 8'd2);
    pulse(1'b1, 1'b1, 1'b1, WON, 2'd3, 8'd3);
    waitc(3);
    do_serve(READY, 2'd3, 8'd0, t);
    waitc(4);

    // Board cleared by the datapath: bricks_left==0 wins
    do_serve(PLAY, 2'd3, 8'd0, t);
    push_ev(t + 1, WON, 2'd3, 8'd0);
    bricks_left = 8'd0;
    @(negedge clk);
    bricks_left = 8'd50;
    waitc(3);
    do_serve(READY, 2'd3, 8'd0, t);
    waitc(4);

    // Pause at count 2, inputs ignored while paused, resume ticks one cycle later
    do_serve(PLAY, 2'd3, 8'd0, t);
    do_pause(PAUSED, 2'd3, 8'd0, c);
    btn_serve = 1'b1;
    pulse(1'b0, 1'b1, 1'b0, PAUSED, 2'd3, 8'd0);
    pulse(1'b1, 1'b0, 1'b0, PAUSED, 2'd3, 8'd0);
    waitc(2);
    btn_serve = 1'b0;
    wait_until(t + 8);
    do_pause(PLAY, 2'd3, 8'd0, c);
    tick_q.push_back(c + 1);
    wait_until(c + 3);
    pulse(1'b1, 1'b0, 1'b1, LOST, 2'd2, 8'd0);
    push_ev(cyc + 8, READY, 2'd2, 8'd0);
    waitc(10);

    // Asynchronous reset while PAUSED with serve held; no serve until re-pressed
    do_serve(PLAY, 2'd2, 8'd0, t);
    do_pause(PAUSED, 2'd2, 8'd0, c);
    waitc(1);
    btn_serve = 1'b1;
    waitc(2);
    push_ev(cyc + 1, READY, 2'd3, 8'd0);
    #2 reset = 1'b0;
    #1;
    check_val("amid_phase", 32'(phase), 32'(READY));
    check_val("amid_lives", 32'(lives), 32'd3);
    check_val("amid_score", 32'(score), 32'd0);
    check_val("amid_ball_tick", 32'(ball_tick), 32'd0);
    check_val("amid_serve", 32'(serve), 32'd0);
    check_val("amid_new_game", 32'(new_game), 32'd0);
    check_val("amid_hold_ball", 32'(hold_ball), 32'd1);
    waitc(2);
    reset = 1'b1;
    waitc(8);
    btn_serve = 1'b0;
    waitc(4);
    do_serve(PLAY, 2'd3, 8'd0, t);
    tick_q.push_back(t + 3);
    tick_q.push_back(t + 7);
    wait_until(t + 9);

    check_val("ev_q_left", ev_q.size(), 32'd0);
    check_val("tick_q_left", tick_q.size(), 32'd0);
    check_val("serve_q_left", serve_q.size(), 32'd0);
    check_val("ng_q_left", ng_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/breakout_sequencer.md
BREAKOUT_SEQUENCER -- requirements
Module: breakout_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter TICK_DIV, default 50000: clk cycles per ball step.
REQ-003 Parameter PAUSE_TICKS, default 120: ball-step periods spent in LOST before returning to READY.
REQ-004 Parameter START_LIVES, default 3: lives loaded at reset and at each new game.
REQ-005 Parameter WIN_SCORE, default 10: score at which the game is won.
REQ-006 clk  in  1  system clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-008 btn_serve  in  1  raw asynchronous serve/new-game button, active-high.
REQ-009 btn_pause  in  1  raw asynchronous pause toggle button, active-high.
REQ-010 ball_out  in  1  one-cycle pulse from datapath: ball passed bottom edge.
REQ-011 brick_hit  in  1  one-cycle pulse from datapath: one brick removed.
REQ-012 bricks_left  in  8  count of visible bricks.
REQ-013 phase  out  3  state: READY=0, PLAY=1, PAUSED=2, LOST=3, OVER=4, WON=5.
REQ-014 ball_tick  out  1  one-cycle ball-step enable.
REQ-015 serve  out  1  one-cycle launch pulse.
REQ-016 hold_ball  out  1  high: datapath parks ball on paddle.
REQ-017 new_game  out  1  one-cycle pulse: datapath restores all bricks.
REQ-018 lives  out  2  remaining lives; score  out  8  bricks destroyed.

Function
REQ-019 Each button SHALL pass a 2-flop synchronizer plus rising-edge detector; a press first sampled high at edge N SHALL cause its transition at edge N+2; a held button SHALL produce one edge only.
REQ-020 READY: hold_ball=1, ball_tick=0; serve edge -> PLAY, serve=1 for exactly the cycle after the transition edge, tick counter cleared to 0.
REQ-021 PLAY: tick counter SHALL count 0..TICK_DIV-1 and wrap; ball_tick=1 in the cycle where count==TICK_DIV-1; first ball_tick TICK_DIV cycles after entering PLAY.
REQ-022 PLAY: brick_hit SHALL increment score, saturating at 255.
REQ-023 PLAY: if bricks_left==0 or score+brick_hit>=WIN_SCORE -> WON, taking priority over ball_out and pause in the same cycle.
REQ-024 PLAY: ball_out with lives>1 -> LOST, lives decremented; ball_out with lives==1 -> OVER, lives=0; ball_out has priority over pause edge.
REQ-025 PLAY: pause edge -> PAUSED; counter value SHALL be frozen, ball_tick=0, ball_out and brick_hit ignored; pause edge in PAUSED -> PLAY resuming from frozen count.
REQ-026 LOST: hold_ball=0, ball_tick=0; counter runs from 0; after PAUSE_TICKS wraps -> READY; buttons ignored.
REQ-027 OVER and WON: ball_tick=0, hold_ball=0, score and lives held; serve edge -> READY with lives=START_LIVES, score=0, new_game=1 for one cycle.
REQ-028 brick_hit and ball_out SHALL be ignored in every state except PLAY; serve edge ignored in PLAY, PAUSED, LOST.
REQ-029 Outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.
REQ-030 Unused phase encodings 6,7 SHALL return to READY on the next edge.

Reset
REQ-031 While reset=0: phase=READY, lives=START_LIVES, score=0, tick and pause counters 0, synchronizers 0, ball_tick=serve=new_game=0, hold_ball=1.
REQ-032 Reset asserted mid-game (any state) SHALL abort immediately; a button held through reset release SHALL NOT generate an edge until released and pressed again.

Verification (TICK_DIV=4, PAUSE_TICKS=2, START_LIVES=3, WIN_SCORE=3)
REQ-033 Reset, press btn_serve -> phase 0->1 two edges after sampling, serve one cycle, ball_tick every 4th cycle starting 4 cycles later, hold_ball 1->0.
REQ-034 In PLAY, three brick_hit pulses -> score 1,2,3; on the third, phase=5, ball_tick stops; serve press -> phase 0, score 0, lives 3, new_game one cycle.
REQ-035 Three ball_out in PLAY with re-serves -> lives 2 (LOST, 8 cycles then READY), 1, then 0 with phase=4.
REQ-036 ball_out and brick_hit reaching WIN_SCORE in same cycle -> phase=5, lives unchanged.
REQ-037 Pause at count 2 -> phase 2, no ticks, brick_hit ignored; unpause -> first ball_tick 1 cycle later.
REQ-038 reset pulled low asynchronously mid-PAUSED with btn_serve held -> all outputs at reset values before next edge; no serve until button re-pressed.
